bus_split_arbiter: RTL and testbench

//  Arbitrates the shared system bus between masters M1/M2 for slaves S1..S3, with split-transaction support.

---
 rtl/bus_split_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bus_split_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_split_arbiter.sv
// bus_split_arbiter: two-master / three-slave bus arbiter with round-robin fairness and a
// single parked split-transaction context that is resumed ahead of new requests or timed out.
module bus_split_arbiter #(
   parameter int SPLIT_TIMEOUT = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m1_request,
   input  logic       m2_request,
   input  logic [1:0] m1_slave_sel,
   input  logic [1:0] m2_slave_sel,
   input  logic       trans_done,
   input  logic       s1_split_en,
   input  logic       s2_split_en,
   input  logic       s3_split_en,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic [1:0] bus_grant,
   output logic [1:0] slave_sel,
   output logic       bus_busy,
   output logic       arbiter_busy,
   output logic       split_pending,
   output logic       split_timeout
);
   localparam int TW = $clog2(SPLIT_TIMEOUT + 1);
   localparam logic [1:0] GNT_M1 = 2'b01;
   localparam logic [1:0] GNT_M2 = 2'b10;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    bus_grant_reg, bus_grant_next;
   logic [1:0]    slave_sel_reg, slave_sel_next;
   logic          rr_last_reg, rr_last_next;             // 1: M2 won the last arbitration
   logic          split_pending_reg, split_pending_next;
   logic          parked_master_reg, parked_master_next; // 1: M2 is parked
   logic [1:0]    parked_slave_reg, parked_slave_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic          split_timeout_reg, split_timeout_next;
   logic          m1_grant_reg, m2_grant_reg, bus_busy_reg, arbiter_busy_reg;

   logic [2:0] split_vec, owner_hit, parked_hit;
   logic       owner_req, owner_split, parked_ready, parked_req, timer_expire;
   logic       m1_elig, m2_elig, m2_wins;

   assign split_vec = {s3_split_en, s2_split_en, s1_split_en};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slave
         assign owner_hit[gi]  = split_vec[gi] && (slave_sel_reg == 2'(gi + 1));
         assign parked_hit[gi] = split_vec[gi] && (parked_slave_reg == 2'(gi + 1));
      end
   endgenerate

   assign owner_req    = bus_grant_reg[1] ? m2_request : m1_request;
   assign owner_split  = |owner_hit;
   assign parked_ready = ~(|parked_hit);
   assign parked_req   = parked_master_reg ? m2_request : m1_request;
   // A parked context stays visible for exactly SPLIT_TIMEOUT cycles after the park edge.
   assign timer_expire = split_pending_reg && (timer_reg == TW'(SPLIT_TIMEOUT - 1));

   assign m1_elig = m1_request && (m1_slave_sel != 2'b00) &&
                    !(split_pending_reg && (!parked_master_reg || (m1_slave_sel == parked_slave_reg)));
   assign m2_elig = m2_request && (m2_slave_sel != 2'b00) &&
                    !(split_pending_reg && (parked_master_reg || (m2_slave_sel == parked_slave_reg)));
   assign m2_wins = m2_elig && (!m1_elig || !rr_last_reg);

   always_comb begin
      state_next         = state_reg;
      bus_grant_next     = bus_grant_reg;
      slave_sel_next     = slave_sel_reg;
      rr_last_next       = rr_last_reg;
      split_pending_next = split_pending_reg;
      parked_master_next = parked_master_reg;
      parked_slave_next  = parked_slave_reg;
      timer_next         = split_pending_reg ? timer_reg + 1'b1 : '0;
      split_timeout_next = 1'b0;

      if (timer_expire) begin
         split_pending_next = 1'b0;
         split_timeout_next = 1'b1;
         timer_next         = '0;
      end

      case (state_reg)
         IDLE: begin
            if (!timer_expire) begin
               if (split_pending_reg && parked_ready && parked_req) begin
                  state_next         = GRANT;
                  bus_grant_next     = parked_master_reg ? GNT_M2 : GNT_M1;
                  slave_sel_next     = parked_slave_reg;
                  split_pending_next = 1'b0;
                  timer_next         = '0;
               end else begin
                  // Parked slave became ready but its master walked away: drop the context.
                  if (split_pending_reg && parked_ready) begin
                     split_pending_next = 1'b0;
                     timer_next         = '0;
                  end
                  if (m1_elig || m2_elig) begin
                     state_next     = GRANT;
                     bus_grant_next = m2_wins ? GNT_M2 : GNT_M1;
                     slave_sel_next = m2_wins ? m2_slave_sel : m1_slave_sel;
                     rr_last_next   = m2_wins;
                  end
               end
            end
         end
         GRANT: begin
            if (trans_done || !owner_req) begin
               state_next     = IDLE;
               bus_grant_next = 2'b00;
               slave_sel_next = 2'b00;
            end else if (owner_split && !split_pending_reg) begin
               state_next         = IDLE;
               bus_grant_next     = 2'b00;
               slave_sel_next     = 2'b00;
               split_pending_next = 1'b1;
               parked_master_next = bus_grant_reg[1];
               parked_slave_next  = slave_sel_reg;
               timer_next         = '0;
            end
         end
         default: begin
            state_next     = IDLE;
            bus_grant_next = 2'b00;
            slave_sel_next = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg         <= IDLE;
         bus_grant_reg     <= 2'b00;
         slave_sel_reg     <= 2'b00;
         rr_last_reg       <= 1'b1;
         split_pending_reg <= 1'b0;
         parked_master_reg <= 1'b0;
         parked_slave_reg  <= 2'b00;
         timer_reg         <= '0;
         split_timeout_reg <= 1'b0;
         m1_grant_reg      <= 1'b0;
         m2_grant_reg      <= 1'b0;
         bus_busy_reg      <= 1'b0;
         arbiter_busy_reg  <= 1'b0;
      end else begin
         state_reg         <= state_next;
         bus_grant_reg     <= bus_grant_next;
         slave_sel_reg     <= slave_sel_next;
         rr_last_reg       <= rr_last_next;
         split_pending_reg <= split_pending_next;
         parked_master_reg <= parked_master_next;
         parked_slave_reg  <= parked_slave_next;
         timer_reg         <= timer_next;
         split_timeout_reg <= split_timeout_next;
         m1_grant_reg      <= (bus_grant_next == GNT_M1);
         m2_grant_reg      <= (bus_grant_next == GNT_M2);
         bus_busy_reg      <= (state_next == GRANT);
         arbiter_busy_reg  <= (state_next == GRANT) || split_pending_next;
      end
   end

   assign m1_grant      = m1_grant_reg;
   assign m2_grant      = m2_grant_reg;
   assign bus_grant     = bus_grant_reg;
   assign slave_sel     = slave_sel_reg;
   assign bus_busy      = bus_busy_reg;
   assign arbiter_busy  = arbiter_busy_reg;
   assign split_pending = split_pending_reg;
   assign split_timeout = split_timeout_reg;
endmodule

// File: tb/tb_bus_split_arbiter.sv
`timescale 1ns/1ps
// Directed bench for bus_split_arbiter: a cycle-level reference model compared every cycle,
// plus literal expectations for each scenario.
module tb_bus_split_arbiter;
   localparam int SPLIT_TIMEOUT = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       m1_request = 1'b0, m2_request = 1'b0;
   logic [1:0] m1_slave_sel = 2'b00, m2_slave_sel = 2'b00;
   logic       trans_done = 1'b0;
   logic       s1_split_en = 1'b0, s2_split_en = 1'b0, s3_split_en = 1'b0;
   logic       m1_grant, m2_grant, bus_busy, arbiter_busy, split_pending, split_timeout;
   logic [1:0] bus_grant, slave_sel;

   bus_split_arbiter #(.SPLIT_TIMEOUT(SPLIT_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m1_request(m1_request), .m2_request(m2_request),
      .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
      .trans_done(trans_done),
      .s1_split_en(s1_split_en), .s2_split_en(s2_split_en), .s3_split_en(s3_split_en),
      .m1_grant(m1_grant), .m2_grant(m2_grant),
      .bus_grant(bus_grant), .slave_sel(slave_sel),
      .bus_busy(bus_busy), .arbiter_busy(arbiter_busy),
      .split_pending(split_pending), .split_timeout(split_timeout)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   // Reference model: bus owner (0 none, 1 M1, 2 M2), its slave, last round-robin winner,
   // and the parked split context with its age in cycles.
   int md_own = 0, md_tgt = 0, md_last = 2;
   bit md_pk = 0;
   int md_pk_m = 0, md_pk_s = 0, md_age = 0;
   bit md_tick = 0;
   bit md_started = 0;
   int prev_own = 0;
   logic [9:0] exp_v, act_v;

   function automatic bit slave_busy(input int s);
      case (s)
         1: return s1_split_en;
         2: return s2_split_en;
         3: return s3_split_en;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit wants(input int m);
      return (m == 1) ? m1_request : m2_request;
   endfunction

   task automatic model_step();
      bit had_ctx, expired, resumed, e1, e2;
      int ctx_m, ctx_s, win;
      cycle++;
      if (!rst) begin
         md_own = 0; md_tgt = 0; md_last = 2;
         md_pk = 0; md_pk_m = 0; md_pk_s = 0; md_age = 0; md_tick = 0;
      end else begin
         had_ctx = md_pk; ctx_m = md_pk_m; ctx_s = md_pk_s;
         expired = 0; resumed = 0; md_tick = 0;
         if (had_ctx) begin
            md_age++;
            if (md_age == SPLIT_TIMEOUT) begin
               expired = 1; md_pk = 0; md_tick = 1;
            end
         end
         if (md_own == 0) begin
            if (!expired) begin
               if (had_ctx && !slave_busy(ctx_s)) begin
                  md_pk = 0;
                  if (wants(ctx_m)) begin
                     md_own = ctx_m; md_tgt = ctx_s; resumed = 1;
                  end
               end
               if (!resumed) begin
                  e1 = m1_request && (m1_slave_sel != 0) &&
                       !(had_ctx && (ctx_m == 1 || int'(m1_slave_sel) == ctx_s));
                  e2 = m2_request && (m2_slave_sel != 0) &&
                       !(had_ctx && (ctx_m == 2 || int'(m2_slave_sel) == ctx_s));
                  if (e1 && e2) win = (md_last == 1) ? 2 : 1;
                  else if (e1) win = 1;
                  else if (e2) win = 2;
                  else win = 0;
                  if (win != 0) begin
                     md_own = win;
                     md_tgt = (win == 1) ? int'(m1_slave_sel) : int'(m2_slave_sel);
                     md_last = win;
                  end
               end
            end
         end else begin
            if (trans_done || !wants(md_own)) begin
               md_own = 0; md_tgt = 0;
            end else if (slave_busy(md_tgt) && !had_ctx) begin
               md_pk = 1; md_pk_m = md_own; md_pk_s = md_tgt; md_age = 0;
               md_own = 0; md_tgt = 0;
            end
         end
      end
      md_started = 1;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (md_started) begin
         exp_v = {md_own == 1, md_own == 2, 2'(md_own), 2'(md_tgt), md_own != 0,
                  (md_own != 0) || md_pk, md_pk, md_tick};
         act_v = {m1_grant, m2_grant, bus_grant, slave_sel, bus_busy, arbiter_busy,
                  split_pending, split_timeout};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle_%0d outputs: actual=%b required=%b", cycle, act_v, exp_v);
         end
         if (md_own != 0 && prev_own == 0)
            $display("txn cycle %0d: M%0d granted S%0d", cycle, md_own, md_tgt);
         prev_own = md_own;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      m1_request = 0; m2_request = 0; m1_slave_sel = 0; m2_slave_sel = 0;
      trans_done = 0; s1_split_en = 0; s2_split_en = 0; s3_split_en = 0;
      tick(2);
      rst = 1'b1;
   endtask

   task automatic wait_grant(output int who);
      who = 0;
      for (int i = 0; i < 20 && who == 0; i++) begin
         tick();
         if (bus_grant == 2'b01) who = 1;
         else if (bus_grant == 2'b10) who = 2;
      end
      if (who == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_grant: actual=no grant required=grant within 20 cycles");
      end
   endtask

   task automatic finish_owner(input int m);
      trans_done = 1'b1;
      if (m == 1) m1_request = 1'b0; else m2_request = 1'b0;
      tick();
      trans_done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   int who, pend, pulses;
   int t2_exp[4] = '{1, 2, 1, 2};

   initial begin
      // 1) reset state, single grant, release
      do_reset();
      check("reset_outputs", 16'({m1_grant, m2_grant, bus_grant, slave_sel, bus_busy,
                                  arbiter_busy, split_pending, split_timeout}), 16'd0);
      m1_request = 1; m1_slave_sel = 2'b01;
      tick();
      check("t1_grant", 16'({bus_grant, slave_sel, m1_grant, m2_grant}), 16'b010110);
      finish_owner(1);
      check("t1_release", 16'(bus_grant), 16'd0);

      // 2) round-robin between two persistent requesters
      do_reset();
      m1_request = 1; m2_request = 1; m1_slave_sel = 2'b01; m2_slave_sel = 2'b10;
      for (int k = 0; k < 4; k++) begin
         wait_grant(who);
         check("t2_winner", 16'(who), 16'(t2_exp[k]));
         tick(3);
         trans_done = 1; tick(); trans_done = 0;
      end
      m1_request = 0; m2_request = 0;
      tick(2);

      // 3) split on S2, other master served, parked master resumes first
      do_reset();
      m1_request = 1; m1_slave_sel = 2'b10;
      wait_grant(who);
      check("t3_first", 16'(who), 16'd1);
      s2_split_en = 1; m2_request = 1; m2_slave_sel = 2'b01;
      tick();
      check("t3_parked", 16'({split_pending, bus_grant}), 16'b100);
      check("t3_busy_flags", 16'({bus_busy, arbiter_busy}), 16'b01);
      wait_grant(who);
      check("t3_m2", 16'({who[1:0], slave_sel}), 16'b1001);
      tick(2);
      trans_done = 1; s2_split_en = 0; tick(); trans_done = 0;
      wait_grant(who);
      check("t3_resume", 16'({who[1:0], slave_sel, split_pending}), 16'b01100);
      finish_owner(1);
      wait_grant(who);
      check("t3_m2_after", 16'(who), 16'd2);
      finish_owner(2);

      // 4) request to the parked slave is held off until the resume completes
      do_reset();
      m1_request = 1; m1_slave_sel = 2'b11;
      wait_grant(who);
      s3_split_en = 1; m2_request = 1; m2_slave_sel = 2'b11;
      tick();
      check("t4_parked", 16'(split_pending), 16'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_blocked", 16'(bus_grant), 16'd0);
      end
      s3_split_en = 0;
      wait_grant(who);
      check("t4_resume", 16'({who[1:0], slave_sel}), 16'b0111);
      finish_owner(1);
      wait_grant(who);
      check("t4_m2", 16'({who[1:0], slave_sel}), 16'b1011);
      finish_owner(2);

      // 5) split never completes: dropped after the timeout with one pulse
      do_reset();
      m1_request = 1; m1_slave_sel = 2'b01;
      wait_grant(who);
      s1_split_en = 1;
      tick();
      m1_request = 0;
      pend = 0; pulses = 0;
      for (int i = 0; i < SPLIT_TIMEOUT + 20; i++) begin
         if (split_pending) pend++;
         if (split_timeout) pulses++;
         tick();
      end
      check("t5_pending_cycles", 16'(pend), 16'd256);
      check("t5_pulses", 16'(pulses), 16'd1);
      check("t5_cleared", 16'(split_pending), 16'd0);
      s1_split_en = 0;
      tick();

      // 6) done beats split, invalid target ignored, reset mid-transaction
      do_reset();
      m1_request = 1; m1_slave_sel = 2'b10;
      wait_grant(who);
      tick();
      trans_done = 1; s2_split_en = 1; m1_request = 0;
      tick();
      trans_done = 0; s2_split_en = 0;
      check("t6_done_wins", 16'({split_pending, bus_grant, bus_busy}), 16'd0);
      m1_request = 1; m1_slave_sel = 2'b00;
      tick(3);
      check("t6_invalid_sel", 16'(bus_grant), 16'd0);
      m1_request = 0; m2_request = 1; m2_slave_sel = 2'b01;
      wait_grant(who);
      check("t6_m2", 16'(who), 16'd2);
      rst = 0;
      tick();
      check("t6_reset_mid", 16'({m1_grant, m2_grant, bus_grant, slave_sel, bus_busy,
                                 arbiter_busy, split_pending, split_timeout}), 16'd0);
      m2_request = 0;
      tick();
      rst = 1;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
